lut_config_loader: RTL
======================

// Module: lut_config_loader
// PURPOSE
//  Upstream configuration stage for the 4-input LUT block.
//  - Receives a serial 16-bit truth-table frame over a valid/ready bit stream and buffers it in a shadow register.
//  - Then performs a 16-cycle write burst into the LUT: drives o_addr_load_data, o_Data and o_config_enable.
//  - o_config_enable is low at all other times, so the LUT evaluates normally.
// PARAMETERS
//  LUT_BITS   16  truth-table depth; must equal 2**ADDR_W
//  ADDR_W     4   LUT address width
//  LSB_FIRST  1   1: first serial bit -> entry 0; 0: first serial bit -> entry LUT_BITS-1
// PORTS
//  clk               in   1       system clock, rising edge
//  rst_n             in   1       asynchronous, active-low reset
//  i_start           in   1       1-cycle pulse; begins a frame (IDLE only)
//  i_ser_data        in   1       serial config bit
//  i_ser_valid       in   1       i_ser_data valid
//  o_ser_ready       out  1       loader accepts a bit this cycle
//  o_addr_load_data  out  ADDR_W  LUT entry address being written
//  o_Data            out  1       LUT entry value being written
//  o_config_enable   out  1       LUT write enable; high only in WRITE
//  o_busy            out  1       high in any state other than IDLE
//  o_done            out  1       1-cycle pulse: burst complete
//  o_error           out  1       parity failure, sticky (LUT_CFG_PARITY_EN only; else tied 0)
// BEHAVIOUR
//  - Reset (any time, incl. mid-frame or mid-burst):
//    - State goes to IDLE; shadow register and bit counter are cleared.
//    - All outputs are 0. The LUT keeps whatever entries were already written.
//  - FSM: IDLE -> SHIFT -> [PARITY] -> WRITE -> DONE -> IDLE. All outputs are registered.
//  - IDLE: o_ser_ready=0.
//    - i_start=1 -> SHIFT next cycle; clears the counter and o_error.
//    - i_start is ignored in every other state.
//  - SHIFT: o_ser_ready=1. Each cycle with i_ser_valid&o_ser_ready stores one bit:
//    - LSB_FIRST=1: bit k -> shadow[k]. LSB_FIRST=0: bit k -> shadow[15-k].
//    - After the 16th accepted bit, o_ser_ready drops in the next cycle.
//    - Next state is PARITY if the macro is defined, else WRITE.
//    - Valid gaps stall indefinitely; there is no timeout.
//  - WRITE: exactly LUT_BITS cycles with o_config_enable=1.
//    - o_addr_load_data steps 0,1,...,15, one per cycle.
//    - o_Data = shadow[o_addr_load_data] in the same cycle.
//    - Address and data change only on clk edges.
//  - DONE: one cycle. o_done=1, o_config_enable=0, o_addr_load_data=0, o_Data=0. Then IDLE.
//  - Latency without parity: last bit accepted on edge N -> o_config_enable=1 from edge N+1.
//    o_done=1 on edge N+17. Frame-to-done = 16 accepted bits + 17 cycles.
//  - Counter is ADDR_W+1 bits wide, so terminal count 16 is detectable. No wrap-around in SHIFT or WRITE.
//  - i_ser_valid outside SHIFT/PARITY is ignored; the bit is not consumed.
// CONFIGURATION
//  Macro LUT_CFG_PARITY_EN.
//  - Defined:
//    - After 16 data bits, PARITY state accepts one more bit (o_ser_ready=1).
//    - Even parity: XOR(shadow) ^ parity_bit must be 0.
//    - Pass -> WRITE. Fail -> o_error=1, back to IDLE, no WRITE and no o_done; LUT untouched.
//    - o_error holds until the next accepted i_start or reset.
//  - Undefined: no PARITY state; o_error is constant 0; a frame is exactly 16 bits.
// STRUCTURE
//  - Package lut_cfg_pkg holds:
//    - LUT_BITS=16 and ADDR_W=4 localparams.
//    - The state enum {IDLE, SHIFT, PARITY, WRITE, DONE}, 3 bits.
//  - Single flat module; no sub-module. Shadow register, counter and FSM are small enough to stay in one file.
//  - Top level instantiates lut_config_loader directly ahead of the LUT.
// TESTING
//  1. Reset mid-WRITE (addr=7) -> all outputs 0 next sample; IDLE; a new i_start+frame completes normally.
//  2. LSB_FIRST=1, frame 16'hA5C3 (bit0 first), continuous valid
//     -> writes addr0..15 with data 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
//     Then o_done pulses once. LUT read at i_LUT=0 ->1, i_LUT=2 ->0.
//  3. Same frame with i_ser_valid toggling 1,0,1,0
//     -> only valid cycles consumed; identical write sequence; o_config_enable never high during SHIFT.
//  4. i_start pulsed during SHIFT and during WRITE -> ignored; counter and address sequence unchanged.
//  5. [LUT_CFG_PARITY_EN] frame 16'h0001 + parity 1 -> WRITE, o_done.
//     Same frame + parity 0 -> o_error=1, no o_config_enable, no o_done.
//  6. LSB_FIRST=0, frame 16'h8000 (first bit 1, rest 0) -> only addr15 written with 1; all other entries 0.

Source files
------------

// File: rtl/lut_config_loader_pkg.sv
// Shared constants, FSM state encoding and the frame parity helper for the LUT configuration loader.
package lut_cfg_pkg;

    localparam int LUT_BITS = 16;
    localparam int ADDR_W   = 4;
    localparam int CNT_W    = ADDR_W + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SHIFT  = 3'd1,
        PARITY = 3'd2,
        WRITE  = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Even parity: the frame bits XOR the parity bit must be zero.
    function automatic logic parity_ok(input logic [LUT_BITS-1:0] frame, input logic par);
        return ~((^frame) ^ par);
    endfunction

endpackage

// File: rtl/lut_config_loader_if.sv
// Serial configuration handshake: start pulse plus a valid/ready bit stream.
interface lut_config_loader_if;

    logic i_start;
    logic i_ser_data;
    logic i_ser_valid;
    logic o_ser_ready;

    modport master (
        output i_start,
        output i_ser_data,
        output i_ser_valid,
        input  o_ser_ready
    );

    modport slave (
        input  i_start,
        input  i_ser_data,
        input  i_ser_valid,
        output o_ser_ready
    );

endinterface

// File: rtl/lut_config_loader.sv
// Shifts a 16-bit truth table in serially, then bursts it into the LUT one entry per cycle.
// Optional frame parity check is enabled by defining LUT_CFG_PARITY_EN.
module lut_config_loader
    import lut_cfg_pkg::*;
#(
    parameter int LSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    lut_config_loader_if.slave ser,
    output logic [ADDR_W-1:0] o_addr_load_data,
    output logic              o_Data,
    output logic              o_config_enable,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LUT_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(LUT_BITS);

    state_t                state_q,  state_d;
    logic [CNT_W-1:0]      cnt_q,    cnt_d;
    logic [LUT_BITS-1:0]   shadow_q, shadow_d;
    logic                  ready_q,  ready_d;
    logic [ADDR_W-1:0]     addr_q,   addr_d;
    logic                  data_q,   data_d;
    logic                  cfg_en_q, cfg_en_d;
    logic                  busy_q,   busy_d;
    logic                  done_q,   done_d;
    logic                  error_q,  error_d;

    logic                  accept_s;
    logic [ADDR_W-1:0]     idx_s;

    // ready_q is only ever high in SHIFT/PARITY, so it already gates acceptance by state.
    assign accept_s = ser.i_ser_valid & ready_q;
    // LUT_BITS == 2**ADDR_W, so 15-k is the bitwise inverse of k.
    assign idx_s    = (LSB_FIRST != 0) ? cnt_q[ADDR_W-1:0] : ~cnt_q[ADDR_W-1:0];

    // Next-state and next-output logic; all outputs are registered from these.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        addr_d   = {ADDR_W{1'b0}};
        data_d   = 1'b0;
        cfg_en_d = 1'b0;
        done_d   = 1'b0;
        error_d  = error_q;

        case (state_q)
            IDLE: begin
                if (ser.i_start) begin
                    state_d = SHIFT;
                    cnt_d   = {CNT_W{1'b0}};
                    error_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (accept_s) begin
                    shadow_d[idx_s] = ser.i_ser_data;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = {CNT_W{1'b0}};
`ifdef LUT_CFG_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = WRITE;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
`ifdef LUT_CFG_PARITY_EN
            PARITY: begin
                if (accept_s) begin
                    if (parity_ok(shadow_q, ser.i_ser_data)) begin
                        state_d = WRITE;
                    end else begin
                        state_d = IDLE;
                        error_d = 1'b1;
                    end
                end else begin
                    state_d = PARITY;
                end
            end
`endif
            // Outputs lag the counter by one edge, so enable rises the cycle after entry.
            WRITE: begin
                if (cnt_q == CNT_TERM) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cfg_en_d = 1'b1;
                    addr_d   = cnt_q[ADDR_W-1:0];
                    data_d   = shadow_q[cnt_q[ADDR_W-1:0]];
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase

        ready_d = (state_d == SHIFT) || (state_d == PARITY);
        busy_d  = (state_d != IDLE);
    end

    // State, datapath and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            shadow_q <= {LUT_BITS{1'b0}};
            ready_q  <= 1'b0;
            addr_q   <= {ADDR_W{1'b0}};
            data_q   <= 1'b0;
            cfg_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            ready_q  <= ready_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            cfg_en_q <= cfg_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign ser.o_ser_ready  = ready_q;
    assign o_addr_load_data = addr_q;
    assign o_Data           = data_q;
    assign o_config_enable  = cfg_en_q;
    assign o_busy           = busy_q;
    assign o_done           = done_q;
    assign o_error          = error_q;

endmodule
